param_atomic_controller: RTL and testbench
==========================================

Name: param_atomic_controller

Overview:
- Next-generation sequencer for the atomic ALU: fetches operands from an internal register file, drives the external ALU, writes back results and executes atomic compare-and-swap (CAS).
- Generalised in data width and register count. Adds a start/busy/done handshake, a host register-load port, a CAS success flag and an optional hardwired-zero R0.
- Sits between the command source (syscall issuer) and the combinational ALU.

Parameters:
- DATA_W, 32, operand/result/register width.
- NREG, 8, number of registers; power of two, >=2.
- REG_AW, $clog2(NREG), register index width (derived, do not override).
- OBS_REG, NREG-1, register mirrored on register_out.
- ZERO_R0, 0, 1 = R0 reads 0 and ignores all writes.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- command  in  3+3*REG_AW  {op, ra, rb, rd}; op is the MSBs.
- syscall  in  1  start strobe; sampled only in IDLE.
- busy  out  1  high from DECODE through DONE.
- done  out  1  one-cycle completion pulse.
- wr_en  in  1  host register load; accepted only in IDLE.
- wr_addr  in  REG_AW  host load index.
- wr_data  in  DATA_W  host load value.
- Z  in  1  ALU zero/equal flag.
- y  in  DATA_W  ALU result.
- alu_op_code  out  3  op field of the latched command.
- data_a  out  DATA_W  operand A = R[ra].
- data_b  out  DATA_W  operand B = R[rb].
- register_out  out  DATA_W  live R[OBS_REG].
- cas_ok  out  1  result of the last CAS: 1 = swapped; holds until the next CAS or reset.

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - state=IDLE; all registers 0.
  - busy=0, done=0, cas_ok=0, alu_op_code=0, data_a=0, data_b=0.
  - Reset mid-operation aborts the operation: no write-back, no done pulse.
- IDLE:
  - syscall=1 latches command into cmd_q and moves to DECODE.
  - wr_en=1 writes R[wr_addr]<=wr_data.
  - If wr_en and syscall occur in the same cycle, both are accepted; DECODE sees the new value.
- DECODE: alu_op_code/data_a/data_b are driven from cmd_q and the current registers -> EXECUTE.
- EXECUTE:
  - Operands are held.
  - y and Z are captured into y_q/z_q at the end of the cycle.
  - op==3'b111 -> CAS_SWAP; otherwise -> WRITE_BACK.
- WRITE_BACK: R[rd]<=y_q -> DONE.
- CAS_SWAP:
  - If z_q=1: R[ra]<=R[rd] and R[rd]<=old R[ra] in the same edge; cas_ok<=1.
  - Else: no register change; cas_ok<=0.
  - -> DONE.
  - ra==rd produces no register change, but cas_ok still follows z_q.
- DONE: done=1 for this cycle only -> IDLE.
- Outputs outside DECODE/EXECUTE: alu_op_code=0, data_a=0, data_b=0.
- Latency: syscall sampled at edge T0 -> DECODE at T0+1 -> done high in cycle T0+4, for both op classes. Next syscall is accepted at T0+5.
- syscall or wr_en while busy: ignored and not queued.
- ZERO_R0=1: reads of R0 return 0; writes to R0 (host, write-back or swap) are dropped. In a swap, the other register still takes the value 0.
- Arithmetic is performed by the external ALU only. Widths are exact; no truncation inside the block.

Decomposition:
- atomic_alu_pkg:
  - state enum ctrl_state_t {IDLE, DECODE, EXECUTE, WRITE_BACK, CAS_SWAP, DONE}.
  - Opcode constants OP_ADD=3'b000 … OP_CAS=3'b111.
- Sub-module ctrl_regfile (params DATA_W, NREG, ZERO_R0):
  - 2 async read ports plus observe port.
  - 2 sync write ports; port 1 has priority when addresses collide.
  - Host load and write-back are muxed onto port 0; swap uses both ports.

Test Plan:
- Reset with command/syscall toggling -> busy=0, done=0, register_out=0, data_a=data_b=0 after the first edge.
- ADD: load R1=0x12345678, R2=0xACDFBAFE; command {000,1,2,7}, syscall for 1 cycle; bench ALU returns y=0xBF141176 -> done at T0+4, register_out=0xBF141176.
- CAS hit: R1=5, R2=5, R3=9; command {111,1,2,3}, Z=1 in EXECUTE -> R1=9, R3=5, cas_ok=1.
- CAS miss: same setup with Z=0 -> R1=5, R3=9 unchanged, cas_ok=0, done still at T0+4.
- syscall and wr_en asserted during busy -> ignored (register unchanged, no second done). Back-to-back ops at T0 and T0+5 -> two done pulses, R7 = 0x11111111 then 0x22222222.
- ZERO_R0=1 build: host writes 0xFFFF to R0 -> R0 reads 0; ADD {000,0,1,0} leaves R0=0. Reset asserted in EXECUTE -> no write-back, no done.

Source files
------------

// File: rtl/atomic_alu_pkg.sv
// atomic_alu_pkg: controller state encoding and ALU opcode constants
package atomic_alu_pkg;
  typedef enum logic [2:0] {IDLE, DECODE, EXECUTE, WRITE_BACK, CAS_SWAP, DONE} ctrl_state_t;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_CAS = 3'b111;
endpackage

// File: rtl/ctrl_regfile.sv
// ctrl_regfile: register file with two async reads, an observe port and two sync writes
module ctrl_regfile #(
  parameter int DATA_W  = 32,
  parameter int NREG    = 8,
  parameter int ZERO_R0 = 0,
  parameter int AW      = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     ra_addr,
  input  logic [AW-1:0]     rb_addr,
  input  logic [AW-1:0]     obs_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  output logic [DATA_W-1:0] obs_data,
  input  logic              we0,
  input  logic [AW-1:0]     wa0,
  input  logic [DATA_W-1:0] wd0,
  input  logic              we1,
  input  logic [AW-1:0]     wa1,
  input  logic [DATA_W-1:0] wd1
);
  logic [DATA_W-1:0] regs [NREG];
  function automatic logic [DATA_W-1:0] rd(input logic [AW-1:0] a);
    return (ZERO_R0 != 0 && a == '0) ? '0 : regs[a];
  endfunction
  always_comb begin
    ra_data  = rd(ra_addr);
    rb_data  = rd(rb_addr);
    obs_data = rd(obs_addr);
  end
  // port 1 is written last so it wins on an address collision
  always_ff @(posedge clk)
    if (rst)
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    else begin
      if (we0 && !(ZERO_R0 != 0 && wa0 == '0)) regs[wa0] <= wd0;
      if (we1 && !(ZERO_R0 != 0 && wa1 == '0)) regs[wa1] <= wd1;
    end
endmodule

// File: rtl/param_atomic_controller.sv
// param_atomic_controller: sequences register fetch, external ALU execution, write-back and CAS
module param_atomic_controller
  import atomic_alu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int NREG    = 8,
  parameter int REG_AW  = $clog2(NREG),
  parameter int OBS_REG = NREG - 1,
  parameter int ZERO_R0 = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3+3*REG_AW-1:0] command,
  input  logic                  syscall,
  output logic                  busy,
  output logic                  done,
  input  logic                  wr_en,
  input  logic [REG_AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  Z,
  input  logic [DATA_W-1:0]     y,
  output logic [2:0]            alu_op_code,
  output logic [DATA_W-1:0]     data_a,
  output logic [DATA_W-1:0]     data_b,
  output logic [DATA_W-1:0]     register_out,
  output logic                  cas_ok
);
  ctrl_state_t state;
  logic [3+3*REG_AW-1:0] cmd_q;
  logic [DATA_W-1:0] y_q, rf_a, rf_b;
  logic z_q, drive, swap, we0;
  logic [2:0] op;
  logic [REG_AW-1:0] ra, rb, rd, rb_sel, wa0;
  logic [DATA_W-1:0] wd0;
  always_comb begin
    op     = cmd_q[3*REG_AW +: 3];
    ra     = cmd_q[2*REG_AW +: REG_AW];
    rb     = cmd_q[REG_AW +: REG_AW];
    rd     = cmd_q[0 +: REG_AW];
    drive  = state == DECODE || state == EXECUTE;
    swap   = state == CAS_SWAP && z_q;
    rb_sel = state == CAS_SWAP ? rd : rb;
    we0    = (state == IDLE && wr_en) || state == WRITE_BACK || swap;
    wa0    = state == IDLE ? wr_addr : state == WRITE_BACK ? rd : ra;
    wd0    = state == IDLE ? wr_data : state == WRITE_BACK ? y_q : rf_b;
    alu_op_code = drive ? op : 3'b000;
    data_a = drive ? rf_a : '0;
    data_b = drive ? rf_b : '0;
  end
  ctrl_regfile #(.DATA_W(DATA_W), .NREG(NREG), .ZERO_R0(ZERO_R0), .AW(REG_AW)) u_rf (
    .clk(clk), .rst(rst),
    .ra_addr(ra), .rb_addr(rb_sel), .obs_addr(REG_AW'(OBS_REG)),
    .ra_data(rf_a), .rb_data(rf_b), .obs_data(register_out),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(swap), .wa1(rd), .wd1(rf_a)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state  <= IDLE;
      cmd_q  <= '0;
      y_q    <= '0;
      z_q    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      cas_ok <= 1'b0;
    end else
      case (state)
        IDLE: if (syscall) begin
          cmd_q <= command;
          busy  <= 1'b1;
          state <= DECODE;
        end
        DECODE: state <= EXECUTE;
        EXECUTE: begin
          y_q   <= y;
          z_q   <= Z;
          state <= op == OP_CAS ? CAS_SWAP : WRITE_BACK;
        end
        WRITE_BACK: begin
          done  <= 1'b1;
          state <= DONE;
        end
        CAS_SWAP: begin
          cas_ok <= z_q;
          done   <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_param_atomic_controller.sv
// tb_param_atomic_controller: directed checks of sequencing, CAS, busy filtering and hardwired R0
module tb_param_atomic_controller;
  logic clk = 0, rst = 1, syscall = 0, wr_en = 0, Z = 0;
  logic [11:0] command = '0;
  logic [2:0] wr_addr = '0;
  logic [31:0] wr_data = '0, y = '0;
  logic busy, done, cas_ok, busy_z, done_z, cas_ok_z;
  logic [2:0] alu_op_code, alu_op_code_z;
  logic [31:0] data_a, data_b, register_out, data_a_z, data_b_z, register_out_z;
  logic [31:0] got_a, got_b, got_az, got_bz;
  logic [2:0] got_op;
  int got_dc, n_checks = 0, n_fail = 0, pulses;

  always #5 clk = ~clk;

  param_atomic_controller #(.DATA_W(32), .NREG(8), .ZERO_R0(0)) dut (
    .clk(clk), .rst(rst), .command(command), .syscall(syscall), .busy(busy), .done(done),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .Z(Z), .y(y),
    .alu_op_code(alu_op_code), .data_a(data_a), .data_b(data_b),
    .register_out(register_out), .cas_ok(cas_ok));

  param_atomic_controller #(.DATA_W(32), .NREG(8), .ZERO_R0(1)) dut_z (
    .clk(clk), .rst(rst), .command(command), .syscall(syscall), .busy(busy_z), .done(done_z),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .Z(Z), .y(y),
    .alu_op_code(alu_op_code_z), .data_a(data_a_z), .data_b(data_b_z),
    .register_out(register_out_z), .cas_ok(cas_ok_z));

  task check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task wr(input logic [2:0] a, input logic [31:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 0;
  endtask

  // issue one command; optionally hammer syscall/wr_en while busy
  task run_op(input logic [11:0] cmd, input logic [31:0] yv, input logic zv, input logic noise);
    command = cmd; y = yv; Z = zv; syscall = 1;
    @(posedge clk); #1;
    syscall = 0; got_dc = 0;
    got_a = data_a; got_b = data_b; got_az = data_a_z; got_bz = data_b_z;
    check("busy_decode", busy, 1);
    if (noise) begin syscall = 1; wr_en = 1; wr_addr = 3'd1; wr_data = 32'hDEADBEEF; end
    for (int i = 1; i <= 10 && got_dc == 0; i++) begin
      if (i == 2) got_op = alu_op_code;
      if (done) got_dc = i;
      else begin @(posedge clk); #1; end
    end
    syscall = 0; wr_en = 0;
    check("done_latency", got_dc, 4);
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
    check("idle_not_busy", busy, 0);
  endtask

  initial begin
    syscall = 1; command = 12'hFFF;
    @(posedge clk); #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_regout", register_out, 0);
    check("rst_data_a", data_a, 0);
    check("rst_data_b", data_b, 0);
    check("rst_op", alu_op_code, 0);
    check("rst_cas_ok", cas_ok, 0);
    syscall = 0; @(posedge clk); #1;
    syscall = 1; @(posedge clk); #1;
    rst = 0; syscall = 0;
    check("rst_still_idle", busy, 0);

    wr(3'd1, 32'h12345678); wr(3'd2, 32'hACDFBAFE);
    run_op({3'b000, 3'd1, 3'd2, 3'd7}, 32'hBF141176, 0, 0);
    check("add_a", got_a, 32'h12345678);
    check("add_b", got_b, 32'hACDFBAFE);
    check("add_op", got_op, 3'b000);
    check("add_r7", register_out, 32'hBF141176);

    wr(3'd1, 5); wr(3'd2, 5); wr(3'd3, 9);
    run_op({3'b111, 3'd1, 3'd2, 3'd3}, 32'h0, 1, 0);
    check("cas_op", got_op, 3'b111);
    check("cas_hit_ok", cas_ok, 1);
    run_op({3'b000, 3'd1, 3'd3, 3'd0}, 32'h0, 0, 0);
    check("cas_hit_r1", got_a, 9);
    check("cas_hit_r3", got_b, 5);

    wr(3'd1, 5); wr(3'd3, 9);
    run_op({3'b111, 3'd1, 3'd2, 3'd3}, 32'h0, 0, 0);
    check("cas_miss_ok", cas_ok, 0);
    run_op({3'b000, 3'd1, 3'd3, 3'd0}, 32'h0, 0, 0);
    check("cas_miss_r1", got_a, 5);
    check("cas_miss_r3", got_b, 9);
    check("cas_ok_holds", cas_ok, 0);

    run_op({3'b000, 3'd1, 3'd2, 3'd7}, 32'h11111111, 0, 1);
    check("b2b_first", register_out, 32'h11111111);
    run_op({3'b000, 3'd1, 3'd2, 3'd7}, 32'h22222222, 0, 0);
    check("busy_wr_ignored", got_a, 5);
    check("b2b_second", register_out, 32'h22222222);

    wr(3'd0, 32'h0000FFFF); wr(3'd1, 32'h42);
    run_op({3'b000, 3'd0, 3'd1, 3'd0}, 32'h1234, 0, 0);
    check("z_host_r0", got_az, 0);
    check("z_r1", got_bz, 32'h42);
    check("nz_host_r0", got_a, 32'h0000FFFF);
    run_op({3'b111, 3'd0, 3'd1, 3'd1}, 32'h0, 1, 0);
    check("z_cas_ok", cas_ok_z, 1);
    run_op({3'b111, 3'd1, 3'd3, 3'd1}, 32'h0, 1, 0);
    check("same_reg_cas_ok", cas_ok, 1);
    run_op({3'b000, 3'd0, 3'd1, 3'd2}, 32'h0, 0, 0);
    check("nz_swap_r0", got_a, 32'h42);
    check("nz_swap_r1", got_b, 32'h1234);
    check("z_swap_r0", got_az, 0);
    check("z_swap_r1", got_bz, 0);

    command = {3'b000, 3'd1, 3'd2, 3'd7}; y = 32'h77777777; syscall = 1;
    @(posedge clk); #1; syscall = 0;
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) pulses++;
      @(posedge clk); #1;
    end
    check("abort_no_done", pulses, 0);
    check("abort_busy", busy, 0);
    check("abort_regout", register_out, 0);
    run_op({3'b000, 3'd1, 3'd2, 3'd7}, 32'h77777777, 0, 0);
    check("after_abort_r7", register_out, 32'h77777777);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
